cache_refill_arbiter: RTL
=========================

Name: cache_refill_arbiter

Overview:
- Shares the single external memory port between I-cache line refills, D-cache line refills and D-side single-word write-through stores.
- Sequences each transaction as an address phase followed by a data phase.
- Drives the Istall and Dstall signals that freeze the pipeline registers, including the MEM/WB register, while either side waits.
- Sits between both cache controllers and the memory/bus interface.

Parameters:
- DATA_W, 32, data and address width (equals `data_size).
- LINE_WORDS, 4, words per cache line; power of two, at least 2.
- CNT_W, $clog2(LINE_WORDS), beat counter width (derived).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_miss  in  1  I-cache miss pending; level, held until i_done
- i_addr  in  DATA_W  I miss address, any alignment
- d_req  in  1  D-side request pending; level, held until d_done
- d_we  in  1  1 = single-word store, 0 = line refill
- d_addr  in  DATA_W  D address
- d_wdata  in  DATA_W  store data
- mem_req  out  1  address-phase request
- mem_we  out  1  write request
- mem_addr  out  DATA_W  line-aligned address for refills, word address for stores
- mem_wdata  out  DATA_W  store data
- mem_ready  in  1  memory accepts the address phase
- mem_rvalid  in  1  read beat valid
- mem_rdata  in  DATA_W  read beat data
- refill_data  out  DATA_W  equals mem_rdata
- refill_idx  out  CNT_W  word index of the current beat
- i_refill_we  out  1  write the beat into the I-cache
- d_refill_we  out  1  write the beat into the D-cache
- i_done  out  1  one-cycle completion pulse, I side
- d_done  out  1  one-cycle completion pulse, D side
- Istall  out  1  i_miss && !i_done
- Dstall  out  1  d_req && !d_done

Behaviour:
- States: IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA, D_WRITE.
- IDLE arbitration, fixed priority D over I (the D request belongs to the older instruction):
  - d_req && d_we goes to D_WRITE.
  - d_req && !d_we goes to D_ADDR.
  - Otherwise i_miss goes to I_ADDR.
- Requester address and store data are latched on leaving IDLE. The latched values drive mem_addr and mem_wdata.
- Refill address: low log2(LINE_WORDS)+2 bits forced to 0. Example: 0x0000_1234 becomes 0x0000_1230.
- *_ADDR states and D_WRITE:
  - mem_req = 1; mem_we = 1 only in D_WRITE.
  - mem_req, mem_we, mem_addr and mem_wdata are held stable until mem_ready.
- On mem_ready:
  - I_ADDR goes to I_DATA, D_ADDR goes to D_DATA; the beat counter is cleared to 0.
  - D_WRITE goes to IDLE with d_done = 1 in the same cycle.
- *_DATA states:
  - Each mem_rvalid asserts the matching *_refill_we with refill_idx = counter, then the counter increments.
  - On the beat where counter == LINE_WORDS-1, *_done = 1 in the same cycle and the next state is IDLE.
  - The counter wraps to 0 and is not used past the last beat.
- Beat timing: one IDLE cycle always separates transactions, so a pending request is granted on the cycle after the previous done. mem_rvalid gaps between beats are allowed and no timeout is applied.
- Ignored inputs:
  - mem_rvalid outside *_DATA: no cache write.
  - mem_ready outside the address states.
- Request drop mid-transaction (for example a flush): the transaction still completes, refill writes still occur and done still pulses. The arbiter never aborts a bus transaction.
- Simultaneous i_miss and d_req: D is served first and Istall stays high throughout. The pipeline is frozen, so no new D request can starve I.
- Reset values (rst_n = 0, asynchronous):
  - State = IDLE; counter and latched registers = 0.
  - mem_req, mem_we, mem_addr, mem_wdata = 0.
  - *_refill_we, *_done, refill_idx = 0.
  - Istall = i_miss, Dstall = d_req (combinational).
  - Reset mid-burst drops the transaction. Beats arriving after reset release are ignored because the state is IDLE.
- Combinational outputs: refill_data, *_refill_we, *_done, Istall, Dstall. The mem_* outputs are derived from state and latched registers only (no input-to-mem_* path).

Decomposition:
- Shared package (with `data_size):
  - Arbiter state enum.
  - LINE_WORDS and the line-offset width constant.
  - Line-align mask function.
- One sub-module is natural: refill_beat_counter (clear, enable, index, last flag). Everything else stays in the top FSM.

Test Plan:
- I-only miss: i_miss = 1, i_addr = 0x0000_0104, mem_ready on the 2nd cycle, 4 back-to-back beats A0..A3 -> mem_addr = 0x0000_0100, i_refill_we on 4 cycles with idx 0,1,2,3, i_done on beat 3, Istall falls that cycle, Dstall stays 0.
- Simultaneous request: i_miss and d_req (d_we = 0, d_addr = 0x2008) rise together -> D_ADDR first with mem_addr = 0x2000, d_done after 4 beats, one IDLE cycle, then I_ADDR; Istall high for the whole D transaction.
- Store: d_req, d_we = 1, d_addr = 0x3004, d_wdata = 0xDEAD_BEEF, mem_ready delayed 3 cycles -> mem_req/mem_we/mem_addr/mem_wdata held stable for 3 cycles, d_done on the mem_ready cycle, no refill_we.
- Gapped beats: beats spaced by 0, 2, 1 idle cycles -> refill_idx increments only on mem_rvalid, done exactly on the 4th beat.
- Reset mid-burst: rst_n low after beat 1 of an I refill, released, then a stray mem_rvalid -> state IDLE, no i_refill_we, all registered outputs 0.
- Dropped request: i_miss deasserts after beat 0 -> remaining 3 beats still written, i_done pulses, next grant follows arbitration.

Source files
------------

// File: rtl/cache_refill_arbiter_pkg.sv
// Shared types and constants for the cache refill arbiter: state encoding,
// line geometry and the line-alignment helper.
`ifndef DATA_SIZE_W
`define DATA_SIZE_W 32
`endif

package cache_refill_arbiter_pkg;

    localparam int DATA_SIZE       = `DATA_SIZE_W;
    localparam int DFLT_LINE_WORDS = 4;
    localparam int LINE_OFF_W      = $clog2(DFLT_LINE_WORDS) + 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_I_ADDR,
        ST_I_DATA,
        ST_D_ADDR,
        ST_D_DATA,
        ST_D_WRITE
    } arb_state_e;

    // Clears the byte-in-line offset so refills always start at word 0 of the line.
    function automatic logic [DATA_SIZE-1:0] line_align(input logic [DATA_SIZE-1:0] addr,
                                                         input int                   off_w);
        logic [DATA_SIZE-1:0] mask;
        mask = '1;
        mask = mask << off_w;
        return addr & mask;
    endfunction

endpackage

// File: rtl/cache_refill_arbiter_if.sv
// External memory port shared by both caches: address phase (req/we/addr/wdata,
// accepted by ready) and read data phase (rvalid/rdata).
interface cache_refill_arbiter_if
    import cache_refill_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_SIZE
);
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/cache_refill_arbiter_beat_counter.sv
// Word index within a line refill: cleared at the address phase handshake,
// advanced once per accepted read beat, wrapping after the last word.
module refill_beat_counter #(
    parameter int LINE_WORDS = 4,
    parameter int CNT_W      = $clog2(LINE_WORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] idx_o,
    output logic             last_o
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign idx_o  = cnt_q;
    assign last_o = (cnt_q == CNT_W'(LINE_WORDS - 1));
endmodule

// File: rtl/cache_refill_arbiter.sv
// Arbitrates the single memory port between I refills, D refills and D stores,
// with D served first; generates cache write strobes, done pulses and stalls.
module cache_refill_arbiter
    import cache_refill_arbiter_pkg::*;
#(
    parameter int DATA_W     = DATA_SIZE,
    parameter int LINE_WORDS = DFLT_LINE_WORDS,
    parameter int CNT_W      = $clog2(LINE_WORDS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_miss,
    input  logic [DATA_W-1:0]      i_addr,
    input  logic                   d_req,
    input  logic                   d_we,
    input  logic [DATA_W-1:0]      d_addr,
    input  logic [DATA_W-1:0]      d_wdata,
    cache_refill_arbiter_if.master mem,
    output logic [DATA_W-1:0]      refill_data,
    output logic [CNT_W-1:0]       refill_idx,
    output logic                   i_refill_we,
    output logic                   d_refill_we,
    output logic                   i_done,
    output logic                   d_done,
    output logic                   Istall,
    output logic                   Dstall
);
    localparam int OFF_W = CNT_W + 2;

    arb_state_e        state_q, state_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              cnt_clr, cnt_en, cnt_last;
    logic              req_c, we_c;

    refill_beat_counter #(
        .LINE_WORDS (LINE_WORDS),
        .CNT_W      (CNT_W)
    ) u_beat_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .idx_o  (refill_idx),
        .last_o (cnt_last)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        req_c       = 1'b0;
        we_c        = 1'b0;
        i_refill_we = 1'b0;
        d_refill_we = 1'b0;
        i_done      = 1'b0;
        d_done      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // D belongs to the older instruction, so it always wins.
                if (d_req) begin
                    addr_d  = d_we ? d_addr : line_align(d_addr, OFF_W);
                    wdata_d = d_wdata;
                    state_d = d_we ? ST_D_WRITE : ST_D_ADDR;
                end else if (i_miss) begin
                    addr_d  = line_align(i_addr, OFF_W);
                    state_d = ST_I_ADDR;
                end
            end
            ST_I_ADDR, ST_D_ADDR: begin
                req_c = 1'b1;
                if (mem.mem_ready) begin
                    cnt_clr = 1'b1;
                    state_d = (state_q == ST_I_ADDR) ? ST_I_DATA : ST_D_DATA;
                end
            end
            ST_I_DATA, ST_D_DATA: begin
                if (mem.mem_rvalid) begin
                    cnt_en      = 1'b1;
                    i_refill_we = (state_q == ST_I_DATA);
                    d_refill_we = (state_q == ST_D_DATA);
                    if (cnt_last) begin
                        i_done  = (state_q == ST_I_DATA);
                        d_done  = (state_q == ST_D_DATA);
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_D_WRITE: begin
                req_c = 1'b1;
                we_c  = 1'b1;
                if (mem.mem_ready) begin
                    d_done  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem.mem_req   = req_c;
    assign mem.mem_we    = we_c;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign refill_data   = mem.mem_rdata;
    assign Istall        = i_miss && !i_done;
    assign Dstall        = d_req && !d_done;
endmodule
